dac_spi_driver: RTL and testbench
=================================

DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per SCLK half-period; legal range 2..255.
REQ-002 Parameter CS_IDLE_CYCLES, default 4: minimum nCS-high clocks between frames; legal range 1..255.
REQ-003 Parameter CTRL_BITS, default 2'b00: two control bits prepended to every frame.
REQ-004 Port clk_i, input, 1: system clock; the block has one clock and all logic is on its rising edge.
REQ-005 Port reset_i, input, 1: synchronous, active-high reset.
REQ-006 Port dac_data_i, input, 14: sample word from the host interface stage.
REQ-007 Port dac_data_rdy_i, input, 1: sample strobe; each high cycle delivers one sample.
REQ-008 Port nCS_o, output, 1: DAC chip select, active low.
REQ-009 Port sclk_o, output, 1: serial clock, idle low (SPI mode 0).
REQ-010 Port sdo_o, output, 1: serial data, MSB first.
REQ-011 Port busy_o, output, 1: high whenever the state is not IDLE.
REQ-012 Port frame_done_o, output, 1: one-cycle pulse on the cycle nCS_o returns high after a complete frame.
REQ-013 Port overrun_o, output, 1: one-cycle pulse when a pending sample is overwritten.

Function
REQ-014 The state machine SHALL have exactly four states: IDLE, SHIFT, HOLD and an illegal-state recovery path that returns to IDLE with all outputs at their reset values.
REQ-015 Each frame SHALL be 16 bits, {CTRL_BITS, sample[13:0]}, with bit 15 sent first.
REQ-016 In IDLE, a strobe in cycle N SHALL latch dac_data_i, and in cycle N+1 the block SHALL drive nCS_o low with bit 15 already on sdo_o.
REQ-017 Each bit period SHALL last 2*CLK_DIV clocks: sclk_o low for the first CLK_DIV clocks, then high for the next CLK_DIV clocks.
REQ-018 sdo_o SHALL change only at bit-period boundaries, which coincide with SCLK falling edges or with frame start.
REQ-019 nCS_o SHALL stay low for exactly 32*CLK_DIV clocks, giving 16 rising SCLK edges.
REQ-020 At the end of the frame, nCS_o SHALL go high and sclk_o SHALL be low; frame_done_o SHALL pulse on that same cycle.
REQ-021 HOLD SHALL keep nCS_o high for exactly CS_IDLE_CYCLES clocks.
REQ-022 On HOLD exit, if a sample is pending, the next frame SHALL start on the following cycle, as in REQ-016; otherwise the state SHALL return to IDLE.
REQ-023 A one-deep pending buffer with a valid flag SHALL capture every strobe received while not in IDLE.
REQ-024 A strobe arriving while the pending buffer is valid SHALL overwrite the buffered sample and pulse overrun_o.
REQ-025 If a strobe coincides with the HOLD-exit cycle that launches the pending sample, the pending sample SHALL launch, the new sample SHALL become pending, and overrun_o SHALL NOT pulse.
REQ-026 If a strobe coincides with a HOLD exit while the pending buffer is empty, the new sample SHALL be stored as pending and SHALL launch one cycle later.
REQ-027 dac_data_i SHALL NOT be sampled during a frame; the shift register SHALL be loaded only at frame start.
REQ-028 Back-to-back strobes in consecutive cycles while IDLE SHALL launch the first sample immediately and leave the second pending.
REQ-029 The SCLK divider counter SHALL run only in SHIFT and SHALL be zero on entry to SHIFT.

Reset
REQ-030 While reset_i is high at a clock edge, outputs SHALL be nCS_o=1, sclk_o=0, sdo_o=0, busy_o=0, frame_done_o=0 and overrun_o=0.
REQ-031 Reset SHALL set the state to IDLE and clear the pending flag, shift register and all counters.
REQ-032 A reset asserted mid-frame SHALL abort the frame at that edge: no frame_done_o pulse, and the pending sample is discarded.
REQ-033 The first strobe after reset_i deasserts SHALL be handled exactly as in REQ-016.

Structure
REQ-034 Shared package dac_pkg SHALL hold the state encoding, FRAME_BITS=16 and DATA_W=14.
REQ-035 One sub-module, sclk_tick_gen, SHALL generate the half-period tick from CLK_DIV; the shift register and FSM SHALL remain in dac_spi_driver.

Verification
REQ-036 The bench SHALL cover a single frame: CLK_DIV=4, sample 14'h2AAA, CTRL 00 -> nCS_o low for 128 clocks, 16 SCLK rises, bits 0010101010101010 MSB first, then frame_done_o pulses once.
REQ-037 The bench SHALL cover a queued sample: strobes 14'h3FFF then 14'h0001, 10 clocks apart -> two frames separated by exactly 4 nCS-high clocks, with no overrun_o.
REQ-038 The bench SHALL cover overrun: three strobes (14'h0100, 14'h0200, 14'h0300) during one frame -> frames 14'h0100 then 14'h0300, with exactly one overrun_o pulse.
REQ-039 The bench SHALL cover the HOLD-exit collision: strobe 14'h1234 on the exact cycle a pending 14'h0ABC launches -> frames 0ABC then 1234, with no overrun_o.
REQ-040 The bench SHALL cover reset mid-frame: reset_i for 1 clock at bit 7 -> nCS_o=1 and sclk_o=0 the next cycle, no frame_done_o, and the pending sample is dropped.
REQ-041 The bench SHALL cover the divider minimum: CLK_DIV=2, CS_IDLE_CYCLES=1, continuous strobe every 70 clocks -> every frame is exactly 64 clocks long, the inter-frame gap is at least 1 clock, and no overrun_o occurs.

Source files
------------

// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding and frame geometry for the DAC SPI driver
package dac_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_W     = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    HOLD    = 2'b10,
    RECOVER = 2'b11
  } state_t;

endpackage

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - half-period tick generator for SCLK, cleared whenever disabled
module sclk_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  logic [7:0] count;

  assign tick = enable && (count == 8'(CLK_DIV - 1));

  // Holding the count at zero while disabled guarantees a full first half-period.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/dac_spi_driver.sv
// rtl/dac_spi_driver.sv - 16-bit SPI mode-0 frame driver for a 14-bit DAC with one-deep pending buffer
module dac_spi_driver
  import dac_pkg::*;
#(
  parameter int         CLK_DIV        = 4,
  parameter int         CS_IDLE_CYCLES = 4,
  parameter logic [1:0] CTRL_BITS      = 2'b00
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] dac_data_i,
  input  logic              dac_data_rdy_i,
  output logic              nCS_o,
  output logic              sclk_o,
  output logic              sdo_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              overrun_o
);

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic                  sclk, sclk_n;
  logic [7:0]            hold_cnt, hold_cnt_n;
  logic [DATA_W-1:0]     pend_data, pend_data_n;
  logic                  pend_valid, pend_valid_n;
  logic                  frame_done, frame_done_n;
  logic                  overrun, overrun_n;
  logic                  tick;
  logic                  launch_pend;

  sclk_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk    (clk_i),
    .reset  (reset_i),
    .enable (state == SHIFT),
    .tick   (tick)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      sclk       <= 1'b0;
      hold_cnt   <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      sclk       <= sclk_n;
      hold_cnt   <= hold_cnt_n;
      pend_data  <= pend_data_n;
      pend_valid <= pend_valid_n;
      frame_done <= frame_done_n;
      overrun    <= overrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    bit_cnt_n    = bit_cnt;
    sclk_n       = sclk;
    hold_cnt_n   = hold_cnt;
    pend_data_n  = pend_data;
    pend_valid_n = pend_valid;
    frame_done_n = 1'b0;
    overrun_n    = 1'b0;
    launch_pend  = 1'b0;

    case (state)
      IDLE: begin
        if (pend_valid) begin
          launch_pend  = 1'b1;
          state_n      = SHIFT;
          shreg_n      = {CTRL_BITS, pend_data};
          pend_valid_n = 1'b0;
        end else if (dac_data_rdy_i) begin
          state_n = SHIFT;
          shreg_n = {CTRL_BITS, dac_data_i};
        end
        bit_cnt_n = '0;
        sclk_n    = 1'b0;
      end

      SHIFT: begin
        if (tick) begin
          sclk_n = !sclk;
          // A tick while SCLK is high is the falling edge that closes a bit period.
          if (sclk) begin
            if (bit_cnt == 4'(FRAME_BITS - 1)) begin
              state_n      = HOLD;
              hold_cnt_n   = '0;
              bit_cnt_n    = '0;
              frame_done_n = 1'b1;
            end else begin
              shreg_n   = {shreg[FRAME_BITS-2:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
      end

      HOLD: begin
        if (hold_cnt == 8'(CS_IDLE_CYCLES - 1)) begin
          if (pend_valid) begin
            launch_pend  = 1'b1;
            state_n      = SHIFT;
            shreg_n      = {CTRL_BITS, pend_data};
            pend_valid_n = 1'b0;
            bit_cnt_n    = '0;
            sclk_n       = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          hold_cnt_n = hold_cnt + 8'd1;
        end
      end

      default: begin
        state_n      = IDLE;
        shreg_n      = '0;
        bit_cnt_n    = '0;
        sclk_n       = 1'b0;
        hold_cnt_n   = '0;
        pend_data_n  = '0;
        pend_valid_n = 1'b0;
      end
    endcase

    // A strobe that coincides with the pending sample launching refills the buffer without loss.
    if (dac_data_rdy_i && (state == SHIFT || state == HOLD || (state == IDLE && pend_valid))) begin
      pend_data_n  = dac_data_i;
      pend_valid_n = 1'b1;
      overrun_n    = pend_valid && !launch_pend;
    end
  end

  assign nCS_o        = (state != SHIFT);
  assign sclk_o       = (state == SHIFT) && sclk;
  assign sdo_o        = (state == SHIFT) && shreg[FRAME_BITS-1];
  assign busy_o       = (state == SHIFT) || (state == HOLD);
  assign frame_done_o = frame_done;
  assign overrun_o    = overrun;

endmodule

// File: tb/tb_dac_spi_driver.sv
// tb/tb_dac_spi_driver.sv - self-checking bench for dac_spi_driver with a transaction-level timing model
module tb_dac_spi_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_reset = 1'b1, a_rdy = 1'b0;
  logic [13:0] a_data = '0;
  logic        a_ncs, a_sclk, a_sdo, a_busy, a_fd, a_ov;
  logic        b_reset = 1'b1, b_rdy = 1'b0;
  logic [13:0] b_data = '0;
  logic        b_ncs, b_sclk, b_sdo, b_busy, b_fd, b_ov;

  dac_spi_driver #(.CLK_DIV(4), .CS_IDLE_CYCLES(4), .CTRL_BITS(2'b00)) dut_a (
    .clk_i(clk), .reset_i(a_reset), .dac_data_i(a_data), .dac_data_rdy_i(a_rdy),
    .nCS_o(a_ncs), .sclk_o(a_sclk), .sdo_o(a_sdo), .busy_o(a_busy),
    .frame_done_o(a_fd), .overrun_o(a_ov)
  );

  dac_spi_driver #(.CLK_DIV(2), .CS_IDLE_CYCLES(1), .CTRL_BITS(2'b10)) dut_b (
    .clk_i(clk), .reset_i(b_reset), .dac_data_i(b_data), .dac_data_rdy_i(b_rdy),
    .nCS_o(b_ncs), .sclk_o(b_sclk), .sdo_o(b_sdo), .busy_o(b_busy),
    .frame_done_o(b_fd), .overrun_o(b_ov)
  );

  bit   sel = 1'b0;
  logic m_ncs, m_sclk, m_sdo, m_busy, m_fd, m_ov;
  assign m_ncs  = sel ? b_ncs  : a_ncs;
  assign m_sclk = sel ? b_sclk : a_sclk;
  assign m_sdo  = sel ? b_sdo  : a_sdo;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_fd   = sel ? b_fd   : a_fd;
  assign m_ov   = sel ? b_ov   : a_ov;

  // Frame monitor: reconstructs each nCS-low window from the pins
  int          q_start[$], q_len[$], q_rises[$];
  logic [15:0] q_word[$];
  bit          q_fd[$], q_sclk_low[$];
  int          fd_cnt = 0, ov_cnt = 0, sdo_bad = 0;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, prev_sdo = 1'b0;
  int          cur_start = 0, cur_len = 0, cur_rises = 0;
  logic [15:0] cur_word = '0;

  always @(negedge clk) begin
    if (!m_ncs) begin
      if (prev_ncs) begin
        cur_start <= cyc;
        cur_len   <= 1;
        cur_rises <= 0;
        cur_word  <= '0;
      end else begin
        cur_len <= cur_len + 1;
        if (m_sclk && !prev_sclk) begin
          cur_word  <= {cur_word[14:0], m_sdo};
          cur_rises <= cur_rises + 1;
        end
        if (m_sdo !== prev_sdo && !(prev_sclk && !m_sclk)) sdo_bad <= sdo_bad + 1;
      end
    end
    if (m_ncs && !prev_ncs) begin
      q_start.push_back(cur_start);
      q_len.push_back(cur_len);
      q_rises.push_back(cur_rises);
      q_word.push_back(cur_word);
      q_fd.push_back(m_fd);
      q_sclk_low.push_back(!m_sclk);
    end
    if (m_fd) fd_cnt <= fd_cnt + 1;
    if (m_ov) ov_cnt <= ov_cnt + 1;
    prev_ncs  <= m_ncs;
    prev_sclk <= m_sclk;
    prev_sdo  <= m_sdo;
  end

  int          total = 0, bad = 0;
  int          st_t[$];
  logic [13:0] st_v[$];
  int          ex_start[$];
  logic [13:0] ex_val[$];
  int          ex_ov;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [13:0] v);
    if (sel) begin b_rdy = 1'b1; b_data = v; end
    else begin a_rdy = 1'b1; a_data = v; end
    st_t.push_back(cyc);
    st_v.push_back(v);
    @(posedge clk);
    #1;
    a_rdy = 1'b0;
    b_rdy = 1'b0;
  endtask

  task automatic settle(output bit to);
    int quiet;
    quiet = 0;
    to = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (m_busy) quiet = 0;
      else quiet++;
      if (quiet >= 3) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // Frame schedule from the rules: frame f cycles long, then h nCS-high cycles ending at exit cycle e.
  task automatic model(input int f, input int h);
    int l, e, t;
    bit have, pv;
    logic [13:0] pval;
    ex_start.delete(); ex_val.delete();
    ex_ov = 0; have = 0; pv = 0; l = 0; e = 0; pval = '0;
    foreach (st_t[i]) begin
      t = st_t[i];
      if (have && pv && e <= t) begin
        l = e + 1; e = l + f + h - 1; pv = 0;
        ex_start.push_back(l); ex_val.push_back(pval);
      end
      if (!have || t > e) begin
        l = t + 1; e = l + f + h - 1; have = 1;
        ex_start.push_back(l); ex_val.push_back(st_v[i]);
      end else if (t == e && !pv) begin
        l = t + 2; e = l + f + h - 1;
        ex_start.push_back(l); ex_val.push_back(st_v[i]);
      end else begin
        if (pv) ex_ov++;
        pv = 1; pval = st_v[i];
      end
    end
    if (pv) begin
      ex_start.push_back(e + 1); ex_val.push_back(pval);
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    a_rdy = 1'b1; a_data = 14'h3FFF;
    tick(3);
    total++; if (a_ncs !== 1'b1) begin bad++; $display("FAIL reset_ncs: got %b want 1", a_ncs); end
    total++; if (a_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", a_sclk); end
    total++; if (a_sdo !== 1'b0) begin bad++; $display("FAIL reset_sdo: got %b want 0", a_sdo); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    total++; if (a_fd !== 1'b0 || a_ov !== 1'b0) begin bad++; $display("FAIL reset_pulses: got fd=%b ov=%b want 0 0", a_fd, a_ov); end
    total++; if (b_ncs !== 1'b1 || b_busy !== 1'b0) begin bad++; $display("FAIL reset_b: got ncs=%b busy=%b want 1 0", b_ncs, b_busy); end
    a_rdy = 1'b0;
    a_reset = 1'b0; b_reset = 1'b0;
    tick(3);
  endtask

  task automatic test_single_frame();
    int b, fd0, ov0, t0;
    bit to;
    b = q_word.size(); fd0 = fd_cnt; ov0 = ov_cnt;
    st_t.delete(); st_v.delete();
    strobe(14'h2AAA);
    t0 = st_t[0];
    tick(20);
    total++; if (a_busy !== 1'b1 || a_ncs !== 1'b0) begin bad++; $display("FAIL single_busy: got busy=%b ncs=%b want 1 0", a_busy, a_ncs); end
    settle(to);
    total++; if (to) begin bad++; $display("FAIL single_timeout: got timeout want idle"); end
    total++;
    if (q_word.size() - b !== 1) begin
      bad++; $display("FAIL single_count: got %0d frames want 1", q_word.size() - b);
    end else begin
      total++; if (q_word[b] !== 16'h2AAA) begin bad++; $display("FAIL single_word: got %h want 2aaa", q_word[b]); end
      total++; if (q_len[b] !== 128) begin bad++; $display("FAIL single_len: got %0d want 128", q_len[b]); end
      total++; if (q_rises[b] !== 16) begin bad++; $display("FAIL single_rises: got %0d want 16", q_rises[b]); end
      total++; if (q_start[b] !== t0 + 1) begin bad++; $display("FAIL single_start: got %0d want %0d", q_start[b], t0 + 1); end
      total++; if (q_fd[b] !== 1'b1 || q_sclk_low[b] !== 1'b1) begin bad++; $display("FAIL single_end: got fd=%b sclk_low=%b want 1 1", q_fd[b], q_sclk_low[b]); end
    end
    total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL single_fd_count: got %0d want 1", fd_cnt - fd0); end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL single_ov: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_queued();
    int b, ov0;
    bit to;
    b = q_word.size(); ov0 = ov_cnt;
    st_t.delete(); st_v.delete();
    strobe(14'h3FFF); tick(9); strobe(14'h0001);
    settle(to);
    total++; if (to) begin bad++; $display("FAIL queued_timeout: got timeout want idle"); end
    total++;
    if (q_word.size() - b !== 2) begin
      bad++; $display("FAIL queued_count: got %0d frames want 2", q_word.size() - b);
    end else begin
      total++; if (q_word[b] !== 16'h3FFF || q_word[b+1] !== 16'h0001) begin bad++; $display("FAIL queued_words: got %h %h want 3fff 0001", q_word[b], q_word[b+1]); end
      total++; if (q_start[b+1] - (q_start[b] + 128) !== 4) begin bad++; $display("FAIL queued_gap: got %0d want 4", q_start[b+1] - (q_start[b] + 128)); end
    end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL queued_ov: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_overrun();
    int b, ov0;
    bit to;
    b = q_word.size(); ov0 = ov_cnt;
    st_t.delete(); st_v.delete();
    strobe(14'h0100); tick(10); strobe(14'h0200); tick(10); strobe(14'h0300);
    settle(to);
    total++; if (to) begin bad++; $display("FAIL overrun_timeout: got timeout want idle"); end
    total++;
    if (q_word.size() - b !== 2) begin
      bad++; $display("FAIL overrun_count: got %0d frames want 2", q_word.size() - b);
    end else begin
      total++; if (q_word[b] !== 16'h0100 || q_word[b+1] !== 16'h0300) begin bad++; $display("FAIL overrun_words: got %h %h want 0100 0300", q_word[b], q_word[b+1]); end
    end
    total++; if (ov_cnt - ov0 !== 1) begin bad++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt - ov0); end
  endtask

  task automatic test_collision();
    int b, ov0, t0;
    bit to;
    b = q_word.size(); ov0 = ov_cnt;
    st_t.delete(); st_v.delete();
    strobe(14'h0555);
    t0 = st_t[0];
    tick(4); strobe(14'h0ABC);
    tick(126); strobe(14'h1234);
    settle(to);
    total++; if (to) begin bad++; $display("FAIL collide_timeout: got timeout want idle"); end
    total++; if (st_t[2] !== t0 + 132) begin bad++; $display("FAIL collide_align: got strobe at %0d want %0d", st_t[2], t0 + 132); end
    total++;
    if (q_word.size() - b !== 3) begin
      bad++; $display("FAIL collide_count: got %0d frames want 3", q_word.size() - b);
    end else begin
      total++; if (q_word[b+1] !== 16'h0ABC || q_word[b+2] !== 16'h1234) begin bad++; $display("FAIL collide_words: got %h %h want 0abc 1234", q_word[b+1], q_word[b+2]); end
      total++; if (q_start[b+1] !== t0 + 133 || q_start[b+2] !== t0 + 265) begin bad++; $display("FAIL collide_starts: got %0d %0d want %0d %0d", q_start[b+1], q_start[b+2], t0 + 133, t0 + 265); end
    end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL collide_ov: got %0d want 0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid_frame();
    int b, fd0, t1;
    bit to;
    b = q_word.size(); fd0 = fd_cnt;
    st_t.delete(); st_v.delete();
    strobe(14'h0777); tick(2); strobe(14'h0999);
    tick(55);
    a_reset = 1'b1;
    tick(1);
    a_reset = 1'b0;
    total++; if (a_ncs !== 1'b1 || a_sclk !== 1'b0 || a_busy !== 1'b0) begin bad++; $display("FAIL midrst_outputs: got ncs=%b sclk=%b busy=%b want 1 0 0", a_ncs, a_sclk, a_busy); end
    tick(400);
    total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL midrst_fd: got %0d want 0", fd_cnt - fd0); end
    total++;
    if (q_word.size() - b !== 1) begin
      bad++; $display("FAIL midrst_frames: got %0d frames want 1 aborted", q_word.size() - b);
    end else begin
      total++; if (q_len[b] !== 59) begin bad++; $display("FAIL midrst_len: got %0d want 59", q_len[b]); end
    end
    b = q_word.size();
    st_t.delete(); st_v.delete();
    strobe(14'h1357);
    t1 = st_t[0];
    settle(to);
    total++;
    if (to || q_word.size() - b !== 1) begin
      bad++; $display("FAIL postrst_count: got %0d frames want 1", q_word.size() - b);
    end else begin
      total++; if (q_start[b] !== t1 + 1 || q_word[b] !== 16'h1357) begin bad++; $display("FAIL postrst_frame: got start=%0d word=%h want %0d 1357", q_start[b], q_word[b], t1 + 1); end
    end
  endtask

  task automatic test_random();
    int b, ov0, sb0, n, g;
    bit to;
    b = q_word.size(); ov0 = ov_cnt; sb0 = sdo_bad;
    st_t.delete(); st_v.delete();
    for (int i = 0; i < 24; i++) begin
      strobe(14'($urandom));
      case ($urandom_range(0, 5))
        0:       g = 0;
        1:       g = $urandom_range(1, 3);
        2:       g = $urandom_range(4, 60);
        3:       g = $urandom_range(120, 140);
        default: g = $urandom_range(130, 134);
      endcase
      tick(g);
    end
    settle(to);
    model(128, 4);
    total++; if (to) begin bad++; $display("FAIL random_timeout: got timeout want idle"); end
    total++; if (q_word.size() - b !== ex_start.size()) begin bad++; $display("FAIL random_count: got %0d want %0d", q_word.size() - b, ex_start.size()); end
    n = (q_word.size() - b < ex_start.size()) ? q_word.size() - b : ex_start.size();
    for (int i = 0; i < n; i++) begin
      total++; if (q_start[b+i] !== ex_start[i]) begin bad++; $display("FAIL random_start[%0d]: got %0d want %0d", i, q_start[b+i], ex_start[i]); end
      total++; if (q_word[b+i] !== {2'b00, ex_val[i]}) begin bad++; $display("FAIL random_word[%0d]: got %h want %h", i, q_word[b+i], {2'b00, ex_val[i]}); end
      total++; if (q_len[b+i] !== 128 || q_rises[b+i] !== 16 || q_fd[b+i] !== 1'b1) begin bad++; $display("FAIL random_shape[%0d]: got len=%0d rises=%0d fd=%b want 128 16 1", i, q_len[b+i], q_rises[b+i], q_fd[b+i]); end
    end
    total++; if (ov_cnt - ov0 !== ex_ov) begin bad++; $display("FAIL random_ov: got %0d want %0d", ov_cnt - ov0, ex_ov); end
    total++; if (sdo_bad - sb0 !== 0) begin bad++; $display("FAIL random_sdo_timing: got %0d mid-bit changes want 0", sdo_bad - sb0); end
  endtask

  task automatic test_div_min();
    int b, ov0, n;
    bit to;
    sel = 1'b1;
    tick(3);
    b = q_word.size(); ov0 = ov_cnt;
    st_t.delete(); st_v.delete();
    for (int i = 0; i < 8; i++) begin
      strobe(14'($urandom));
      tick(69);
    end
    settle(to);
    model(64, 1);
    total++; if (to) begin bad++; $display("FAIL divmin_timeout: got timeout want idle"); end
    total++; if (q_word.size() - b !== 8) begin bad++; $display("FAIL divmin_count: got %0d want 8", q_word.size() - b); end
    n = (q_word.size() - b < ex_start.size()) ? q_word.size() - b : ex_start.size();
    for (int i = 0; i < n; i++) begin
      total++; if (q_len[b+i] !== 64) begin bad++; $display("FAIL divmin_len[%0d]: got %0d want 64", i, q_len[b+i]); end
      total++; if (q_word[b+i] !== {2'b10, ex_val[i]} || q_start[b+i] !== ex_start[i]) begin bad++; $display("FAIL divmin_frame[%0d]: got %h@%0d want %h@%0d", i, q_word[b+i], q_start[b+i], {2'b10, ex_val[i]}, ex_start[i]); end
      if (i > 0) begin
        total++; if (q_start[b+i] - (q_start[b+i-1] + 64) < 1) begin bad++; $display("FAIL divmin_gap[%0d]: got %0d want >=1", i, q_start[b+i] - (q_start[b+i-1] + 64)); end
      end
    end
    total++; if (ov_cnt - ov0 !== 0) begin bad++; $display("FAIL divmin_ov: got %0d want 0", ov_cnt - ov0); end
    sel = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_queued();
    test_overrun();
    test_collision();
    test_reset_mid_frame();
    test_random();
    test_div_min();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
